// File: rtl/alu_pkg.sv
// alu_pkg: shared types and default widths for the ALU datapath stages.
// Holds the MAC dot-product stage state encoding and its width defaults.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_e;

    localparam int MAC_ACC_W = 16;
    localparam int MAC_LEN_W = 4;

endpackage

// File: rtl/multiplier_4_x_4.sv
// multiplier_4_x_4: combinational unsigned 4x4 array multiplier.
// Ports: inp1 (4b multiplicand), inp2 (4b multiplier), product (8b).
module multiplier_4_x_4 (
    input  logic [3:0] inp1,
    input  logic [3:0] inp2,
    output logic [7:0] product
);

    // One shifted partial-product row per multiplier bit, summed down.
    always_comb begin
        product = '0;
        for (int i = 0; i < 4; i++) begin
            product = product
                    + ({4'b0000, inp1 & {4{inp2[i]}}} << i);
        end
    end

endmodule

// File: rtl/mac_dot_stage.sv
// mac_dot_stage: sequential saturating dot product over len operand pairs.
// Ports: clk, rst (sync high), start/len, in_valid/in_ready/inp1/inp2,
//        out_valid/out_ready/result, overflow (sticky), busy.
module mac_dot_stage
    import alu_pkg::*;
#(
    parameter int ACC_W = MAC_ACC_W,
    parameter int LEN_W = MAC_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       inp1,
    input  logic [3:0]       inp2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             busy
);

    mac_state_e       state_q;
    logic [LEN_W-1:0] rem_q;
    logic [7:0]       prod_d;
    logic [7:0]       prod_q;
    logic             prod_v;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [ACC_W:0]   sum;
    logic             accept;

    multiplier_4_x_4 u_mul (
        .inp1    (inp1),
        .inp2    (inp2),
        .product (prod_d)
    );

    assign in_ready  = (state_q == ACCUM) && (rem_q != '0);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = acc_q;
    assign overflow  = ovf_q;

    // One spare carry bit catches anything past the accumulator range.
    assign sum = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            prod_q  <= '0;
            prod_v  <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        rem_q   <= len;
                        prod_v  <= 1'b0;
                        state_q <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        prod_q <= prod_d;
                        prod_v <= 1'b1;
                        rem_q  <= rem_q - 1'b1;
                    end else begin
                        prod_v <= 1'b0;
                    end
                    if (prod_v) begin
                        if (sum[ACC_W]) begin
                            acc_q <= '1;
                            ovf_q <= 1'b1;
                        end else begin
                            acc_q <= sum[ACC_W-1:0];
                        end
                        // Last product lands together with the exit.
                        if (rem_q == '0) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_stage.sv
// tb_mac_dot_stage: scoreboard bench for mac_dot_stage.
// Drives a 16-bit and a 10-bit accumulator instance with shared stimulus.
module tb_mac_dot_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [3:0] inp1;
    logic [3:0] inp2;
    logic       out_ready;

    logic        ir16, ov16, of16, bz16;
    logic [15:0] r16;
    logic        ir10, ov10, of10, bz10;
    logic [9:0]  r10;

    int cmp_n = 0;
    int err_n = 0;

    typedef struct {
        logic [15:0] r16;
        logic        o16;
        logic [9:0]  r10;
        logic        o10;
    } exp_t;

    exp_t sb[$];
    int   qa[$];
    int   qb[$];

    always #5 clk = ~clk;

    mac_dot_stage #(.ACC_W(16), .LEN_W(4)) u16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (ir16),
        .inp1      (inp1),
        .inp2      (inp2),
        .out_valid (ov16),
        .out_ready (out_ready),
        .result    (r16),
        .overflow  (of16),
        .busy      (bz16)
    );

    mac_dot_stage #(.ACC_W(10), .LEN_W(4)) u10 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (ir10),
        .inp1      (inp1),
        .inp2      (inp2),
        .out_valid (ov10),
        .out_ready (out_ready),
        .result    (r10),
        .overflow  (of10),
        .busy      (bz10)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: saturating sums at both widths over qa/qb.
    task automatic push_model(input int n);
        exp_t e;
        int s16 = 0;
        int s10 = 0;
        e.o16 = 1'b0;
        e.o10 = 1'b0;
        for (int i = 0; i < n; i++) begin
            s16 += qa[i] * qb[i];
            s10 += qa[i] * qb[i];
            if (s16 > 65535) begin
                s16 = 65535;
                e.o16 = 1'b1;
            end
            if (s10 > 1023) begin
                s10 = 1023;
                e.o10 = 1'b1;
            end
        end
        e.r16 = 16'(s16);
        e.r10 = 10'(s10);
        sb.push_back(e);
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = 4'(l);
        cyc();
        start = 1'b0;
    endtask

    // Offers pairs; gaps toggles valid 1,0,1,0,1 then holds it high
    // (with filler pairs) until the result appears.
    task automatic feed(input int n, input bit gaps, output int acc);
        int k = 0;
        for (int i = 0; i < 40; i++) begin
            if (!gaps && k == n) break;
            if (ov16) break;
            in_valid = (gaps && i < 5) ? (i % 2 == 0) : 1'b1;
            inp1 = (k < qa.size()) ? 4'(qa[k]) : 4'd9;
            inp2 = (k < qb.size()) ? 4'(qb[k]) : 4'd9;
            if (in_valid && ir16) k++;
            cyc();
        end
        in_valid = 1'b0;
        acc = k;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ov16) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        inp1 = '0;
        inp2 = '0;
        out_ready = 1'b0;
        cyc();
        cyc();
        cmp_n++;
        if ({ir16, ov16, r16, of16, bz16, ir10, ov10, r10, of10, bz10} !== '0) begin
            err_n++;
            $display("FAIL reset_outputs got r16=%0d r10=%0d ir=%b ov=%b of=%b bz=%b want all 0",
                     r16, r10, ir16, ov16, of16, bz16);
        end
        rst = 1'b0;
        cyc();
        cmp_n++;
        if ({ov16, bz16, ir16, r16} !== '0) begin
            err_n++;
            $display("FAIL reset_idle got ov=%b bz=%b ir=%b r=%0d want 0", ov16, bz16, ir16, r16);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int acc;
        qa = {3, 15, 2};
        qb = {5, 15, 7};
        push_model(3);
        do_start(3);
        cmp_n++;
        if (bz16 !== 1'b1 || ir16 !== 1'b1) begin
            err_n++;
            $display("FAIL basic_busy got bz=%b ir=%b want 1 1", bz16, ir16);
        end
        feed(3, 1'b0, acc);
        cmp_n++;
        if (acc != 3) begin
            err_n++;
            $display("FAIL basic_accepts got %0d want 3", acc);
        end
        cmp_n++;
        if (ir16 !== 1'b0 || ov16 !== 1'b0) begin
            err_n++;
            $display("FAIL basic_after_last got ir=%b ov=%b want 0 0", ir16, ov16);
        end
        cyc();
        cmp_n++;
        if (ov16 !== 1'b1) begin
            err_n++;
            $display("FAIL basic_latency got out_valid=%b want 1", ov16);
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        cmp_n++;
        if ({r16, of16, r10, of10} !== {e.r16, e.o16, e.r10, e.o10}) begin
            err_n++;
            $display("FAIL basic_result got %0d/%b %0d/%b want %0d/%b %0d/%b",
                     r16, of16, r10, of10, e.r16, e.o16, e.r10, e.o10);
        end
        cyc();
        out_ready = 1'b0;
        cmp_n++;
        if (ov16 !== 1'b0 || bz16 !== 1'b0) begin
            err_n++;
            $display("FAIL basic_idle got ov=%b bz=%b want 0 0", ov16, bz16);
        end
    endtask

    task automatic test_gaps_backpressure();
        exp_t e;
        int acc;
        qa = {3, 15, 2};
        qb = {5, 15, 7};
        push_model(3);
        do_start(3);
        feed(3, 1'b1, acc);
        cmp_n++;
        if (acc != 3 || ov16 !== 1'b1) begin
            err_n++;
            $display("FAIL gaps_accepts got %0d ov=%b want 3 1", acc, ov16);
        end
        for (int h = 0; h < 4; h++) begin
            cmp_n++;
            if (ov16 !== 1'b1 || r16 !== sb[0].r16) begin
                err_n++;
                $display("FAIL hold_stable cycle %0d got ov=%b r=%0d want 1 %0d",
                         h, ov16, r16, sb[0].r16);
            end
            cyc();
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        cmp_n++;
        if ({r16, of16, r10, of10} !== {e.r16, e.o16, e.r10, e.o10}) begin
            err_n++;
            $display("FAIL gaps_result got %0d/%b %0d/%b want %0d/%b %0d/%b",
                     r16, of16, r10, of10, e.r16, e.o16, e.r10, e.o10);
        end
        cyc();
        out_ready = 1'b0;
        cmp_n++;
        if (ov16 !== 1'b0 || bz16 !== 1'b0 || ir16 !== 1'b0) begin
            err_n++;
            $display("FAIL gaps_idle got ov=%b bz=%b ir=%b want 0 0 0", ov16, bz16, ir16);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        int acc;
        bit ok;
        qa = {};
        qb = {};
        for (int i = 0; i < 5; i++) begin
            qa.push_back(15);
            qb.push_back(15);
        end
        push_model(5);
        do_start(5);
        feed(5, 1'b0, acc);
        wait_out(ok);
        cmp_n++;
        if (!ok) begin
            err_n++;
            $display("FAIL sat_timeout got no out_valid want out_valid within 40 cycles");
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        cmp_n++;
        if ({r16, of16, r10, of10} !== {e.r16, e.o16, e.r10, e.o10}) begin
            err_n++;
            $display("FAIL sat_result got %0d/%b %0d/%b want %0d/%b %0d/%b",
                     r16, of16, r10, of10, e.r16, e.o16, e.r10, e.o10);
        end
        cyc();
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            cmp_n++;
            if (r10 !== e.r10 || of10 !== 1'b1 || ov10 !== 1'b0) begin
                err_n++;
                $display("FAIL sat_idle_hold got r=%0d of=%b ov=%b want %0d 1 0",
                         r10, of10, ov10, e.r10);
            end
            cyc();
        end
    endtask

    task automatic test_empty();
        exp_t e;
        qa = {};
        qb = {};
        push_model(0);
        in_valid = 1'b1;
        inp1 = 4'd6;
        inp2 = 4'd6;
        do_start(0);
        cmp_n++;
        if (ov16 !== 1'b1 || ir16 !== 1'b0 || of10 !== 1'b0) begin
            err_n++;
            $display("FAIL empty_done got ov=%b ir=%b of10=%b want 1 0 0", ov16, ir16, of10);
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        cmp_n++;
        if ({r16, of16, r10, of10} !== {e.r16, e.o16, e.r10, e.o10}) begin
            err_n++;
            $display("FAIL empty_result got %0d/%b %0d/%b want %0d/%b %0d/%b",
                     r16, of16, r10, of10, e.r16, e.o16, e.r10, e.o10);
        end
        cyc();
        out_ready = 1'b0;
        in_valid = 1'b0;
        cmp_n++;
        if (ov16 !== 1'b0 || bz16 !== 1'b0 || r16 !== 16'd0) begin
            err_n++;
            $display("FAIL empty_idle got ov=%b bz=%b r=%0d want 0 0 0", ov16, bz16, r16);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int acc;
        bit ok;
        qa = {1, 3, 4, 5};
        qb = {2, 3, 4, 5};
        do_start(4);
        feed(2, 1'b0, acc);
        rst = 1'b1;
        cyc();
        cmp_n++;
        if ({ir16, ov16, r16, of16, bz16, ir10, ov10, r10, of10, bz10} !== '0) begin
            err_n++;
            $display("FAIL midrun_reset got r16=%0d ir=%b ov=%b of=%b bz=%b want all 0",
                     r16, ir16, ov16, of16, bz16);
        end
        rst = 1'b0;
        qa = {4};
        qb = {4};
        push_model(1);
        do_start(1);
        feed(1, 1'b0, acc);
        wait_out(ok);
        cmp_n++;
        if (!ok || acc != 1) begin
            err_n++;
            $display("FAIL restart_run got ok=%b accepts=%0d want 1 1", ok, acc);
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        cmp_n++;
        if ({r16, of16, r10, of10} !== {e.r16, e.o16, e.r10, e.o10}) begin
            err_n++;
            $display("FAIL restart_result got %0d/%b %0d/%b want %0d/%b %0d/%b",
                     r16, of16, r10, of10, e.r16, e.o16, e.r10, e.o10);
        end
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_ignored_start();
        exp_t e;
        int acc;
        bit ok;
        qa = {5, 7};
        qb = {6, 8};
        push_model(2);
        do_start(2);
        start = 1'b1;
        len = 4'd7;
        feed(2, 1'b0, acc);
        start = 1'b0;
        wait_out(ok);
        cmp_n++;
        if (!ok || acc != 2) begin
            err_n++;
            $display("FAIL ign_run got ok=%b accepts=%0d want 1 2", ok, acc);
        end
        start = 1'b1;
        len = 4'd7;
        out_ready = 1'b1;
        e = sb.pop_front();
        cmp_n++;
        if ({r16, of16, r10, of10} !== {e.r16, e.o16, e.r10, e.o10}) begin
            err_n++;
            $display("FAIL ign_result got %0d/%b %0d/%b want %0d/%b %0d/%b",
                     r16, of16, r10, of10, e.r16, e.o16, e.r10, e.o10);
        end
        cyc();
        start = 1'b0;
        out_ready = 1'b0;
        for (int h = 0; h < 2; h++) begin
            cmp_n++;
            if (bz16 !== 1'b0 || ov16 !== 1'b0 || ir16 !== 1'b0) begin
                err_n++;
                $display("FAIL ign_idle cycle %0d got bz=%b ov=%b ir=%b want 0 0 0",
                         h, bz16, ov16, ir16);
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_backpressure();
        test_saturation();
        test_empty();
        test_reset_mid_run();
        test_ignored_start();
        cmp_n++;
        if (sb.size() != 0) begin
            err_n++;
            $display("FAIL sb_drained got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
